// File: rtl/way_sel_pipe_mux.sv
// N-way cache read-data selector: one-hot way select picks one packed entry of a set.
// Output is a valid/ready stream behind a 2-entry skid buffer; malformed selects are flagged and counted.
module way_sel_pipe_mux #(
    parameter int unsigned WAYS            = 4,
    parameter int unsigned LINE_SIZE_BYTES = 4,
    parameter int unsigned LRU_BITS        = 1,
    parameter int unsigned VALID_BITS      = 1,
    parameter int unsigned DIRTY_BITS      = 1,
    parameter int unsigned TAG_BITS        = 18,
    parameter int unsigned ERR_CNT_BITS    = 8,
    localparam int unsigned LINE_W  = LINE_SIZE_BYTES * 8,
    localparam int unsigned ENTRY_W = VALID_BITS + LRU_BITS + DIRTY_BITS + TAG_BITS + LINE_W,
    localparam int unsigned WAY_W   = $clog2(WAYS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [WAYS*ENTRY_W-1:0]   i_data,
    input  logic [WAYS-1:0]           i_sel,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [LINE_W-1:0]         o_data,
    output logic [TAG_BITS-1:0]       o_tag,
    output logic [DIRTY_BITS-1:0]     o_dirty,
    output logic [VALID_BITS-1:0]     o_line_vld,
    output logic [WAY_W-1:0]          o_way,
    output logic                      o_sel_err,
    output logic [ERR_CNT_BITS-1:0]   o_err_cnt
);

    localparam int unsigned TAG_LSB   = LINE_W;
    localparam int unsigned DIRTY_LSB = TAG_LSB + TAG_BITS;
    localparam int unsigned LRU_LSB   = DIRTY_LSB + DIRTY_BITS;
    localparam int unsigned VALID_LSB = LRU_LSB + LRU_BITS;

    typedef struct packed {
        logic [LINE_W-1:0]     data;
        logic [TAG_BITS-1:0]   tag;
        logic [DIRTY_BITS-1:0] dirty;
        logic [VALID_BITS-1:0] line_vld;
        logic [WAY_W-1:0]      way;
        logic                  sel_err;
    } payload_t;

    payload_t                  dec;
    payload_t                  main_q, main_d;
    payload_t                  skid_q, skid_d;
    logic                      main_valid_q, main_valid_d;
    logic                      skid_valid_q, skid_valid_d;
    logic [ERR_CNT_BITS-1:0]   err_cnt_q, err_cnt_d;

    int unsigned               hot_cnt;
    logic [WAY_W-1:0]          hit_idx;
    logic [LINE_W-1:0]         hit_data;
    logic [TAG_BITS-1:0]       hit_tag;
    logic [DIRTY_BITS-1:0]     hit_dirty;
    logic [VALID_BITS-1:0]     hit_vld;
    logic                      unused_lru;

    logic                      accept;
    logic                      consume;

    always_comb begin
        hot_cnt    = 0;
        hit_idx    = '0;
        hit_data   = '0;
        hit_tag    = '0;
        hit_dirty  = '0;
        hit_vld    = '0;
        unused_lru = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            unused_lru = unused_lru ^ (^i_data[w*ENTRY_W + LRU_LSB +: LRU_BITS]);
            if (i_sel[w]) begin
                hot_cnt   = hot_cnt + 1;
                hit_idx   = WAY_W'(w);
                hit_data  = i_data[w*ENTRY_W +: LINE_W];
                hit_tag   = i_data[w*ENTRY_W + TAG_LSB +: TAG_BITS];
                hit_dirty = i_data[w*ENTRY_W + DIRTY_LSB +: DIRTY_BITS];
                hit_vld   = i_data[w*ENTRY_W + VALID_LSB +: VALID_BITS];
            end
        end
    end

    // Zero-hot and multi-hot selects yield an all-zero payload rather than an OR of ways.
    always_comb begin
        dec = '0;
        if (hot_cnt == 1) begin
            dec.data     = hit_data;
            dec.tag      = hit_tag;
            dec.dirty    = hit_dirty;
            dec.line_vld = hit_vld;
            dec.way      = hit_idx;
        end else begin
            dec.sel_err  = 1'b1;
        end
    end

    assign accept  = i_valid & ~skid_valid_q;
    assign consume = main_valid_q & i_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (consume) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && dec.sel_err && (err_cnt_q != {ERR_CNT_BITS{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_BITS'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_ready    = ~skid_valid_q;
    assign o_valid    = main_valid_q;
    assign o_data     = main_q.data;
    assign o_tag      = main_q.tag;
    assign o_dirty    = main_q.dirty;
    assign o_line_vld = main_q.line_vld;
    assign o_way      = main_q.way;
    assign o_sel_err  = main_q.sel_err;
    assign o_err_cnt  = err_cnt_q;

endmodule
